// File: rtl/key_debounce_multi_pkg.sv
// key_pkg: shared debounce FSM state encoding and counter width helper
package key_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} key_state_e;

    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: raw key pins in, debounced level and event pulses out
interface key_debounce_multi_if #(parameter int KEY_NUM = 3);
    logic [KEY_NUM-1:0] key;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;
    logic [KEY_NUM-1:0] key_repeat;
    modport master(output key, input key_level, key_press, key_release, key_long, key_repeat);
    modport slave(input key, output key_level, key_press, key_release, key_long, key_repeat);
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one active-low key, synchroniser, debounce FSM, hold timer
module key_debounce_ch import key_pkg::*; #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam int HW = cnt_w(LONG_CYC);

    key_state_e    state, state_nx;
    logic [1:0]    sync;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic s, long_done, d_done, d_run, tick, hit;
    logic press_d, release_d, long_d, repeat_d;

    assign s = sync[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= IDLE;
        end else begin
            sync  <= {sync[0], key};
            state <= state_nx;
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = s ? IDLE : PRESS_DB;
            PRESS_DB: state_nx = s ? IDLE : d_done ? HELD : PRESS_DB;
            HELD:     state_nx = s ? REL_DB : HELD;
            REL_DB:   state_nx = !s ? HELD : d_done ? IDLE : REL_DB;
            default:  state_nx = IDLE;
        endcase
    end

    // hold time keeps ticking on the cycle a release glitch ends, so only true REL_DB cycles pause it
    always_comb begin
        d_done    = dcnt == DW'(DEBOUNCE_CYC - 1);
        d_run     = (state == PRESS_DB && !s) || (state == REL_DB && s);
        press_d   = state == PRESS_DB && !s && d_done;
        release_d = state == REL_DB && s && d_done;
        tick      = !s && (state == HELD || state == REL_DB);
        hit       = tick && hcnt == HW'(LONG_CYC - 1);
        long_d    = hit && !long_done;
        repeat_d  = hit && long_done && REPEAT_EN != 0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dcnt        <= '0;
            hcnt        <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            dcnt        <= (d_run && !d_done) ? dcnt + 1'b1 : '0;
            hcnt        <= press_d ? '0 :
                           hit ? (REPEAT_EN != 0 ? HW'(LONG_CYC - REPEAT_CYC) : hcnt) :
                           tick ? hcnt + 1'b1 : hcnt;
            long_done   <= press_d ? 1'b0 : long_done | long_d;
            key_level   <= press_d ? 1'b0 : release_d ? 1'b1 : key_level;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
            key_repeat  <= repeat_d;
        end
endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: KEY_NUM independent debounce channels side by side
module key_debounce_multi #(
    parameter int KEY_NUM      = 3,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int REPEAT_EN    = 1
) (
    input logic             clk,
    input logic             rst_n,
    key_debounce_multi_if.slave bus
);
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC(LONG_CYC),
            .REPEAT_CYC(REPEAT_CYC),
            .REPEAT_EN(REPEAT_EN)
        ) u_ch (
            .clk(clk),
            .rst_n(rst_n),
            .key(bus.key[i]),
            .key_level(bus.key_level[i]),
            .key_press(bus.key_press[i]),
            .key_release(bus.key_release[i]),
            .key_long(bus.key_long[i]),
            .key_repeat(bus.key_repeat[i])
        );
    end
endmodule
